// File: rtl/counter_sched_pkg.sv
// Shared types and the round-robin winner search for the counter scheduler.
package counter_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int MAX_REQ = 8;

  // First set bit of req searching ptr, ptr+1, ... modulo n (n <= MAX_REQ).
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0] ptr,
                                         input int n);
    logic [2:0] win;
    logic       found;
    int         idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && req[idx[2:0]]) begin
        win   = idx[2:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/down_counter_sync.sv
// Loadable synchronous down counter that saturates at zero.
module down_counter_sync #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec_en,
  output logic [CNT_W-1:0] count,
  output logic             zero_out
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (load_en) begin
      count_reg <= load_val;
    end else if (dec_en && count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count    = count_reg;
  assign zero_out = (count_reg == '0);

endmodule

// File: rtl/counter_rr_sched.sv
// Round-robin scheduler sharing one down counter among NUM_REQ requesters.
module counter_rr_sched
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset_ah_in,
  input  logic                     tick_in,
  input  logic [NUM_REQ-1:0]       req_in,
  input  logic [NUM_REQ*CNT_W-1:0] len_in,
  output logic [NUM_REQ-1:0]       grant_out,
  output logic [NUM_REQ-1:0]       done_out,
  output logic                     busy_out,
  output logic [CNT_W-1:0]         count_out
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   owner_reg, owner_next;
  logic [PTR_W-1:0]   ptr_reg, ptr_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [NUM_REQ-1:0] done_reg, done_next;

  logic               load_en, dec_en, zero;
  logic [CNT_W-1:0]   load_val, count;

  logic [2:0]         win_idx;
  logic [PTR_W-1:0]   win, ptr_inc;
  logic [CNT_W-1:0]   win_len;
  logic [NUM_REQ-1:0] win_onehot;

  always_comb begin
    win_idx    = rr_pick(MAX_REQ'(req_in), 3'(ptr_reg), NUM_REQ);
    win        = PTR_W'(win_idx);
    win_len    = len_in[int'(win)*CNT_W +: CNT_W];
    win_onehot = NUM_REQ'(1) << win;
    ptr_inc    = PTR_W'((int'(owner_reg) + 1) % NUM_REQ);
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    grant_next = grant_reg;
    done_next  = '0;
    load_en    = 1'b0;
    load_val   = '0;
    dec_en     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        grant_next = '0;
        if (|req_in) begin
          owner_next = win;
          grant_next = win_onehot;
          load_en    = 1'b1;
          load_val   = win_len;
          if (win_len != '0) begin
            state_next = S_COUNT;
          end else begin
            state_next = S_DONE;
            done_next  = win_onehot;
          end
        end
      end
      S_COUNT: begin
        // Abort wins over a coincident tick and clears the counter.
        if (!req_in[owner_reg]) begin
          state_next = S_IDLE;
          grant_next = '0;
          load_en    = 1'b1;
          ptr_next   = ptr_inc;
        end else if (tick_in) begin
          dec_en = 1'b1;
          if (count == CNT_W'(1) || zero) begin
            state_next = S_DONE;
            done_next  = grant_reg;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        grant_next = '0;
        ptr_next   = ptr_inc;
      end
      default: begin
        state_next = S_IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_ah_in) begin
      state_reg <= S_IDLE;
      owner_reg <= '0;
      ptr_reg   <= '0;
      grant_reg <= '0;
      done_reg  <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      done_reg  <= done_next;
    end
  end

  down_counter_sync #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk      (clk),
    .srst     (reset_ah_in),
    .load_en  (load_en),
    .load_val (load_val),
    .dec_en   (dec_en),
    .count    (count),
    .zero_out (zero)
  );

  assign grant_out = grant_reg;
  assign done_out  = done_reg;
  assign busy_out  = (state_reg != S_IDLE);
  assign count_out = count;

endmodule

// File: tb/tb_counter_rr_sched.sv
// Directed checks of the shared-counter round-robin scheduler.
module tb_counter_rr_sched;

  logic        clk = 1'b0;
  logic        reset_ah_in;
  logic        tick_in;
  logic [3:0]  req_in;
  logic [15:0] len_in;
  logic [3:0]  grant_out;
  logic [3:0]  done_out;
  logic        busy_out;
  logic [3:0]  count_out;

  int n_vec = 0;
  int n_err = 0;

  counter_rr_sched #(
    .NUM_REQ(4),
    .CNT_W  (4)
  ) dut (
    .clk        (clk),
    .reset_ah_in(reset_ah_in),
    .tick_in    (tick_in),
    .req_in     (req_in),
    .len_in     (len_in),
    .grant_out  (grant_out),
    .done_out   (done_out),
    .busy_out   (busy_out),
    .count_out  (count_out)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] d,
                         input logic b, input logic [3:0] c);
    chk({tag, ".grant"}, 32'(grant_out), 32'(g));
    chk({tag, ".done"},  32'(done_out),  32'(d));
    chk({tag, ".busy"},  32'(busy_out),  32'(b));
    chk({tag, ".count"}, 32'(count_out), 32'(c));
  endtask

  task automatic do_reset();
    reset_ah_in = 1'b1;
    req_in      = 4'b0000;
    cyc();
    reset_ah_in = 1'b0;
  endtask

  logic [1:0] rr_order [5];

  initial begin
    reset_ah_in = 1'b1;
    tick_in     = 1'b0;
    req_in      = 4'b0000;
    len_in      = 16'h0000;
    cyc();
    chk_all("reset", 4'b0000, 4'b0000, 1'b0, 4'd0);
    reset_ah_in = 1'b0;
    cyc();
    chk_all("idle_noreq", 4'b0000, 4'b0000, 1'b0, 4'd0);

    // Single requester, len=3, tick tied high; len change after grant ignored.
    req_in  = 4'b0001;
    len_in  = {4'd0, 4'd0, 4'd0, 4'd3};
    tick_in = 1'b1;
    cyc(); chk_all("single.t1", 4'b0001, 4'b0000, 1'b1, 4'd3);
    len_in  = {4'd0, 4'd0, 4'd0, 4'd7};
    cyc(); chk_all("single.t2", 4'b0001, 4'b0000, 1'b1, 4'd2);
    cyc(); chk_all("single.t3", 4'b0001, 4'b0000, 1'b1, 4'd1);
    cyc(); chk_all("single.t4", 4'b0001, 4'b0001, 1'b1, 4'd0);
    req_in = 4'b0000;
    cyc(); chk_all("single.t5", 4'b0000, 4'b0000, 1'b0, 4'd0);

    // Zero length: grant and done together, straight to DONE.
    req_in = 4'b0100;
    len_in = {4'd0, 4'd0, 4'd0, 4'd0};
    cyc(); chk_all("zero.done", 4'b0100, 4'b0100, 1'b1, 4'd0);
    req_in = 4'b0000;
    cyc(); chk_all("zero.idle", 4'b0000, 4'b0000, 1'b0, 4'd0);

    // Round robin from ptr=0 with everyone requesting len=1.
    do_reset();
    rr_order[0] = 2'd0; rr_order[1] = 2'd1; rr_order[2] = 2'd2;
    rr_order[3] = 2'd3; rr_order[4] = 2'd0;
    req_in = 4'b1111;
    len_in = {4'd1, 4'd1, 4'd1, 4'd1};
    for (int k = 0; k < 5; k++) begin
      cyc(); chk_all($sformatf("rr%0d.grant", k), 4'b0001 << rr_order[k], 4'b0000, 1'b1, 4'd1);
      cyc(); chk_all($sformatf("rr%0d.done", k), 4'b0001 << rr_order[k], 4'b0001 << rr_order[k], 1'b1, 4'd0);
      cyc(); chk_all($sformatf("rr%0d.idle", k), 4'b0000, 4'b0000, 1'b0, 4'd0);
    end
    req_in = 4'b0000;
    cyc(); chk_all("rr.quiet", 4'b0000, 4'b0000, 1'b0, 4'd0);

    // Tick gating: len=2, ticks 1,0,0,1 in COUNT.
    do_reset();
    req_in  = 4'b0001;
    len_in  = {4'd0, 4'd0, 4'd0, 4'd2};
    tick_in = 1'b1;
    cyc(); chk_all("gate.load", 4'b0001, 4'b0000, 1'b1, 4'd2);
    tick_in = 1'b1;
    cyc(); chk_all("gate.tick1", 4'b0001, 4'b0000, 1'b1, 4'd1);
    tick_in = 1'b0;
    cyc(); chk_all("gate.hold1", 4'b0001, 4'b0000, 1'b1, 4'd1);
    cyc(); chk_all("gate.hold2", 4'b0001, 4'b0000, 1'b1, 4'd1);
    tick_in = 1'b1;
    cyc(); chk_all("gate.done", 4'b0001, 4'b0001, 1'b1, 4'd0);
    req_in = 4'b0000;
    cyc(); chk_all("gate.idle", 4'b0000, 4'b0000, 1'b0, 4'd0);

    // Abort: req0 drops after 3 ticks, req2 waiting gets the next grant.
    do_reset();
    req_in  = 4'b0101;
    len_in  = {4'd0, 4'd5, 4'd0, 4'd9};
    tick_in = 1'b1;
    cyc(); chk_all("abort.load", 4'b0001, 4'b0000, 1'b1, 4'd9);
    cyc(); chk("abort.c8", 32'(count_out), 32'd8);
    cyc(); chk("abort.c7", 32'(count_out), 32'd7);
    cyc(); chk("abort.c6", 32'(count_out), 32'd6);
    req_in = 4'b0100;
    cyc(); chk_all("abort.idle", 4'b0000, 4'b0000, 1'b0, 4'd0);
    cyc(); chk_all("abort.regrant", 4'b0100, 4'b0000, 1'b1, 4'd5);

    // Reset in the middle of an interval: no done pulse afterwards.
    do_reset();
    chk_all("midrst.pre", 4'b0000, 4'b0000, 1'b0, 4'd0);
    req_in  = 4'b0001;
    len_in  = {4'd0, 4'd0, 4'd0, 4'd5};
    tick_in = 1'b1;
    cyc(); chk_all("midrst.load", 4'b0001, 4'b0000, 1'b1, 4'd5);
    cyc(); cyc(); chk("midrst.c3", 32'(count_out), 32'd3);
    reset_ah_in = 1'b1;
    cyc(); chk_all("midrst.rst", 4'b0000, 4'b0000, 1'b0, 4'd0);
    reset_ah_in = 1'b0;
    req_in      = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      cyc(); chk_all($sformatf("midrst.after%0d", k), 4'b0000, 4'b0000, 1'b0, 4'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
